// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared bus header: arbiter state encoding, owner encoding, hold counter width.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package yutorina_bus_arbiter_pkg;

    localparam int ARB_ST_W = 2;

    localparam logic [ARB_ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ARB_ST_W-1:0] ST_OWN0 = 2'd1;
    localparam logic [ARB_ST_W-1:0] ST_OWN1 = 2'd2;

    localparam logic BUS_OWNER_M0 = 1'b0;
    localparam logic BUS_OWNER_M1 = 1'b1;

    localparam int HOLD_CNT_W = 8;

    // Maps a master index onto the state in which that master owns the bus.
    function automatic logic [ARB_ST_W-1:0] own_state(input logic idx);
        return (idx == BUS_OWNER_M1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/yutorina_bus_arbiter_if.sv
// Two-master bus arbitration signals: active-low requests/strobes/ready in, grants and owner out.
// Latency: n/a (wiring only).
// Backpressure: masters wait for their own grant; the slave paces transfers with m_rdy_.
interface yutorina_bus_arbiter_if;

    logic m0_req_;
    logic m0_as_;
    logic m1_req_;
    logic m1_as_;
    logic m_rdy_;
    logic m0_grnt_;
    logic m1_grnt_;
    logic owner;

    // Master side: requests, strobes and the returned ready; receives the grants.
    modport master (
        output m0_req_, m0_as_, m1_req_, m1_as_, m_rdy_,
        input  m0_grnt_, m1_grnt_, owner
    );

    // Arbiter side.
    modport slave (
        input  m0_req_, m0_as_, m1_req_, m1_as_, m_rdy_,
        output m0_grnt_, m1_grnt_, owner
    );

endinterface

// File: rtl/yutorina_arb_hold_counter.sv
// Hold counter: counts cycles the current owner keeps the bus while the other master waits.
// Latency: expired reflects the registered count (1 cycle after the counting edge).
// Backpressure: none; saturates at all-ones. Present only with YUTORINA_ARB_TIMEOUT_EN.
`ifdef YUTORINA_ARB_TIMEOUT_EN
module yutorina_arb_hold_counter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [HOLD_CNT_W-1:0] LIMIT = HOLD_CNT_W'(HOLD_MAX - 1);

    logic [HOLD_CNT_W-1:0] cnt;

    // Clear wins over increment so a state change always restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // At or beyond the limit; the count may run on while the owner is mid-transfer.
    assign expired = (cnt >= LIMIT);

endmodule
`endif

// File: rtl/yutorina_bus_arbiter.sv
// Two-master round-robin bus arbiter (CPU m0, DMAC m1); optional hold timeout via YUTORINA_ARB_TIMEOUT_EN.
// Latency: grant 1 cycle after a request from IDLE; direct swap of grants in a single edge on release.
// Backpressure: owner keeps the bus while requesting or while a transfer awaits m_rdy_; never pre-empts mid-transfer.
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    yutorina_bus_arbiter_if.slave bus
);

    if ((HOLD_MAX < 2) || (HOLD_MAX > ((1 << HOLD_CNT_W) - 1))) begin : g_hold_max_range
        $error("yutorina_bus_arbiter: HOLD_MAX out of range");
    end

    logic [ARB_ST_W-1:0] state;
    logic [ARB_ST_W-1:0] state_nxt;
    logic                owner_q;
    logic                last_q;
    logic                outst_q;
    logic                m0_grnt_q;
    logic                m1_grnt_q;

    logic                r0;
    logic                r1;
    logic                own_req;
    logic                oth_req;
    logic                own_as;
    logic                quiet;
    logic                pre_empt;

    assign r0 = ~bus.m0_req_;
    assign r1 = ~bus.m1_req_;

    // Only the owner's strobe matters; the other master's as_ never reaches the logic.
    assign own_req = (state == ST_OWN1) ? r1 : r0;
    assign oth_req = (state == ST_OWN1) ? r0 : r1;
    assign own_as  = (state == ST_OWN0) ? ~bus.m0_as_ :
                     (state == ST_OWN1) ? ~bus.m1_as_ : 1'b0;

    // Bus may change hands only between transfers.
    assign quiet = ~own_as & ~outst_q;

`ifdef YUTORINA_ARB_TIMEOUT_EN
    logic hold_expired;

    yutorina_arb_hold_counter #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_nxt != state),
        .inc     (((state == ST_OWN0) || (state == ST_OWN1)) && oth_req),
        .expired (hold_expired)
    );

    assign pre_empt = hold_expired & oth_req;
`else
    assign pre_empt = 1'b0;
`endif

    // Next-state: round-robin on ties from IDLE, release or pre-empt from an OWN state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (r0 && r1) begin
                    state_nxt = own_state(~last_q);
                end else if (r0) begin
                    state_nxt = ST_OWN0;
                end else if (r1) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (quiet && (!own_req || pre_empt)) begin
                    if (oth_req) begin
                        state_nxt = (state == ST_OWN0) ? ST_OWN1 : ST_OWN0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, grants and owner all register from state_nxt so they move on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            m0_grnt_q <= 1'b1;
            m1_grnt_q <= 1'b1;
            owner_q   <= BUS_OWNER_M0;
            last_q    <= BUS_OWNER_M1;
        end else begin
            state     <= state_nxt;
            m0_grnt_q <= (state_nxt != ST_OWN0);
            m1_grnt_q <= (state_nxt != ST_OWN1);
            if (state_nxt == ST_OWN0) begin
                owner_q <= BUS_OWNER_M0;
                last_q  <= BUS_OWNER_M0;
            end else if (state_nxt == ST_OWN1) begin
                owner_q <= BUS_OWNER_M1;
                last_q  <= BUS_OWNER_M1;
            end
        end
    end

    // Outstanding transfer: opened by the owner's strobe without ready, closed by ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst_q <= 1'b0;
        end else if (!bus.m_rdy_) begin
            outst_q <= 1'b0;
        end else if (own_as) begin
            outst_q <= 1'b1;
        end
    end

    assign bus.m0_grnt_ = m0_grnt_q;
    assign bus.m1_grnt_ = m1_grnt_q;
    assign bus.owner    = owner_q;

endmodule
